// File: rtl/guest_list_solver_pkg.sv
// Shared types for the guest list solver: FSM state codes and the popcount width helper.
package guest_list_solver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width needed to hold a popcount of 0..n_guests inclusive.
    function automatic int count_width(input int n_guests);
        return $clog2(n_guests + 1);
    endfunction

endpackage

// File: rtl/guest_list_solver_if.sv
// Control, rule-configuration and solution-stream bundle for guest_list_solver.
// Define SOLVER_COUNT_EN to add the sol_count signal.
interface guest_list_solver_if
    import guest_list_solver_pkg::*;
#(
    parameter int N_GUESTS = 4,
    parameter int N_RULES  = 8
);
    localparam int RA = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam int CW = count_width(N_GUESTS);

    logic                cfg_we;
    logic [RA-1:0]       cfg_addr;
    logic                cfg_en;
    logic [N_GUESTS-1:0] cfg_pos;
    logic [N_GUESTS-1:0] cfg_neg;
    logic [N_GUESTS-1:0] cfg_con;
    logic [CW-1:0]       min_guests;
    logic [CW-1:0]       max_guests;
    logic                start;
    logic                busy;
    logic                done;
    logic                sol_valid;
    logic                sol_ready;
    logic [N_GUESTS-1:0] sol_data;
`ifdef SOLVER_COUNT_EN
    logic [N_GUESTS:0]   sol_count;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_en, cfg_pos, cfg_neg, cfg_con,
        output min_guests, max_guests, start, sol_ready,
        input  busy, done, sol_valid, sol_data
`ifdef SOLVER_COUNT_EN
        , input sol_count
`endif
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_en, cfg_pos, cfg_neg, cfg_con,
        input  min_guests, max_guests, start, sol_ready,
        output busy, done, sol_valid, sol_data
`ifdef SOLVER_COUNT_EN
        , output sol_count
`endif
    );

endinterface

// File: rtl/guest_rule_check.sv
// Combinational check of one candidate subset against the whole rule table and the popcount window.
module guest_rule_check
    import guest_list_solver_pkg::*;
#(
    parameter int N_GUESTS = 4,
    parameter int N_RULES  = 8,
    parameter int CW       = count_width(N_GUESTS)
) (
    input  logic [N_GUESTS-1:0]         cand,
    input  logic [N_RULES-1:0]          rule_en,
    input  logic [N_RULES*N_GUESTS-1:0] rule_pos,
    input  logic [N_RULES*N_GUESTS-1:0] rule_neg,
    input  logic [N_RULES*N_GUESTS-1:0] rule_con,
    input  logic [CW-1:0]               min_g,
    input  logic [CW-1:0]               max_g,
    output logic                        ok
);

    logic          violated;
    logic [CW-1:0] pop;

    // A rule fires when its premise holds and none of its conclusion guests are invited.
    always_comb begin
        violated = 1'b0;
        for (int r = 0; r < N_RULES; r++) begin
            if (rule_en[r]
                && ((cand & rule_pos[r*N_GUESTS +: N_GUESTS]) == rule_pos[r*N_GUESTS +: N_GUESTS])
                && ((cand & rule_neg[r*N_GUESTS +: N_GUESTS]) == '0)
                && ((cand & rule_con[r*N_GUESTS +: N_GUESTS]) == '0)) begin
                violated = 1'b1;
            end
        end
    end

    assign pop = CW'($countones(cand));
    assign ok  = !violated && (pop >= min_g) && (pop <= max_g);

endmodule

// File: rtl/guest_list_solver.sv
// Rule table, scan FSM and registered solution output; streams every valid guest subset in order.
// Define SOLVER_COUNT_EN to add the sol_count counter of accepted solutions.
module guest_list_solver
    import guest_list_solver_pkg::*;
#(
    parameter int N_GUESTS = 4,
    parameter int N_RULES  = 8
) (
    input  logic         clk,
    input  logic         reset,
    guest_list_solver_if.slave bus
);

    localparam int                  CW        = count_width(N_GUESTS);
    localparam logic [N_GUESTS-1:0] CAND_LAST = '1;

    state_e                      state_q, state_d;
    logic [N_GUESTS-1:0]         cand_q, cand_d;
    logic [CW-1:0]               min_q, min_d;
    logic [CW-1:0]               max_q, max_d;
    logic [N_RULES-1:0]          rule_en_q, rule_en_d;
    logic [N_RULES*N_GUESTS-1:0] rule_pos_q, rule_pos_d;
    logic [N_RULES*N_GUESTS-1:0] rule_neg_q, rule_neg_d;
    logic [N_RULES*N_GUESTS-1:0] rule_con_q, rule_con_d;
    logic                        sol_valid_q, sol_valid_d;
    logic [N_GUESTS-1:0]         sol_data_q, sol_data_d;
    logic                        done_q, done_d;
    logic                        cand_ok;
    logic                        slot_free;

    guest_rule_check #(
        .N_GUESTS (N_GUESTS),
        .N_RULES  (N_RULES),
        .CW       (CW)
    ) u_check (
        .cand     (cand_q),
        .rule_en  (rule_en_q),
        .rule_pos (rule_pos_q),
        .rule_neg (rule_neg_q),
        .rule_con (rule_con_q),
        .min_g    (min_q),
        .max_g    (max_q),
        .ok       (cand_ok)
    );

    // The output slot can take a new subset when empty or being emptied this cycle.
    assign slot_free = !sol_valid_q || bus.sol_ready;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        min_d       = min_q;
        max_d       = max_q;
        rule_en_d   = rule_en_q;
        rule_pos_d  = rule_pos_q;
        rule_neg_d  = rule_neg_q;
        rule_con_d  = rule_con_q;
        sol_valid_d = sol_valid_q;
        sol_data_d  = sol_data_q;
        done_d      = 1'b0;

        if (sol_valid_q && bus.sol_ready) begin
            sol_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we) begin
                    rule_en_d[bus.cfg_addr]                               = bus.cfg_en;
                    rule_pos_d[int'(bus.cfg_addr)*N_GUESTS +: N_GUESTS] = bus.cfg_pos;
                    rule_neg_d[int'(bus.cfg_addr)*N_GUESTS +: N_GUESTS] = bus.cfg_neg;
                    rule_con_d[int'(bus.cfg_addr)*N_GUESTS +: N_GUESTS] = bus.cfg_con;
                end
                if (bus.start) begin
                    state_d = ST_SCAN;
                    cand_d  = '0;
                    min_d   = bus.min_guests;
                    max_d   = bus.max_guests;
                end
            end
            ST_SCAN: begin
                if (slot_free) begin
                    if (cand_ok) begin
                        sol_valid_d = 1'b1;
                        sol_data_d  = cand_q;
                    end
                    if (cand_q == CAND_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cand_d = cand_q + N_GUESTS'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            rule_en_q   <= '0;
            rule_pos_q  <= '0;
            rule_neg_q  <= '0;
            rule_con_q  <= '0;
            sol_valid_q <= 1'b0;
            sol_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            min_q       <= min_d;
            max_q       <= max_d;
            rule_en_q   <= rule_en_d;
            rule_pos_q  <= rule_pos_d;
            rule_neg_q  <= rule_neg_d;
            rule_con_q  <= rule_con_d;
            sol_valid_q <= sol_valid_d;
            sol_data_q  <= sol_data_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.sol_valid = sol_valid_q;
    assign bus.sol_data  = sol_data_q;

`ifdef SOLVER_COUNT_EN
    logic [N_GUESTS:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ST_IDLE && bus.start) begin
            count_d = '0;
        end else if (sol_valid_q && bus.sol_ready) begin
            count_d = count_q + (N_GUESTS+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.sol_count = count_q;
`endif

endmodule

// File: tb/tb_guest_list_solver.sv
// Self-checking bench for guest_list_solver: table-driven scans plus back-pressure, reset-abort and busy-ignore sequences.
module tb_guest_list_solver;
    import guest_list_solver_pkg::*;

    localparam int NG = 4;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    guest_list_solver_if #(.N_GUESTS(NG), .N_RULES(NR)) bus ();

    guest_list_solver #(.N_GUESTS(NG), .N_RULES(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          useRules;
        logic [2:0]  minG;
        logic [2:0]  maxG;
        logic [15:0] expMask;
        int          expN;
        string       name;
    } scan_vec_t;

    scan_vec_t       vecs[6];
    int              total = 0;
    int              bad   = 0;
    logic [NG-1:0]   expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Writes one rule-table entry; called at a falling edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic en,
                                 input logic [NG-1:0] pos, input logic [NG-1:0] neg,
                                 input logic [NG-1:0] con);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_en   = en;
        bus.cfg_pos  = pos;
        bus.cfg_neg  = neg;
        bus.cfg_con  = con;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    // Florencio rules with a=bit0..d=bit3, or an all-disabled table.
    task automatic programRules(input bit florencio);
        if (florencio) begin
            applyStimulus(3'd0, 1'b1, 4'b0010, 4'b0000, 4'b0100);
            applyStimulus(3'd1, 1'b1, 4'b0101, 4'b0000, 4'b1010);
            applyStimulus(3'd2, 1'b1, 4'b0100, 4'b0000, 4'b0010);
            applyStimulus(3'd3, 1'b1, 4'b1000, 4'b0000, 4'b0010);
            applyStimulus(3'd4, 1'b1, 4'b0000, 4'b0001, 4'b0010);
            for (int r = 5; r < NR; r++) applyStimulus(3'(r), 1'b0, 4'b0, 4'b0, 4'b0);
        end else begin
            for (int r = 0; r < NR; r++) applyStimulus(3'(r), 1'b0, 4'b0, 4'b0, 4'b0);
        end
    endtask

    task automatic pushExpected(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) expQ.push_back(NG'(i));
        end
    endtask

    task automatic startScan(input logic [2:0] minG, input logic [2:0] maxG);
        bus.min_guests = minG;
        bus.max_guests = maxG;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        checkOutput("busy after start", 32'(bus.busy), 1);
    endtask

    // Pops the scoreboard on every handshake until done; latency counts edges since start was sampled.
    task automatic collectScan(input int budget, output int nAcc, output int latency);
        logic [NG-1:0] want;
        int            nDone;
        nAcc    = 0;
        nDone   = 0;
        latency = -1;
        for (int k = 0; k < budget; k++) begin
            if (bus.sol_valid && bus.sol_ready) begin
                nAcc++;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra solution: got %0h expected none", bus.sol_data);
                end else begin
                    want = expQ.pop_front();
                    checkOutput("sol_data", 32'(bus.sol_data), 32'(want));
                end
            end
            if (bus.done) begin
                nDone   = 1;
                latency = k;
                checkOutput("busy low with done", 32'(bus.busy), 0);
                break;
            end
            @(negedge clk);
        end
        if (nDone == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL done timeout: got no done expected done within %0d cycles", budget);
        end else begin
            @(negedge clk);
            checkOutput("done single pulse", 32'(bus.done), 0);
        end
        checkOutput("scoreboard drained", 32'(expQ.size()), 0);
    endtask

    initial begin
        int nAcc;
        int lat;
        int acc;
        int doneSeen;
        logic [NG-1:0] want;

        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_en     = 1'b0;
        bus.cfg_pos    = '0;
        bus.cfg_neg    = '0;
        bus.cfg_con    = '0;
        bus.min_guests = '0;
        bus.max_guests = '0;
        bus.start      = 1'b0;
        bus.sol_ready  = 1'b1;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset sol_valid", 32'(bus.sol_valid), 0);
        checkOutput("reset sol_data", 32'(bus.sol_data), 0);
`ifdef SOLVER_COUNT_EN
        checkOutput("reset sol_count", 32'(bus.sol_count), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Rules come out of reset disabled, so every subset is a solution.
        pushExpected(16'hFFFF);
        startScan(3'd0, 3'd4);
        collectScan(60, nAcc, lat);
        checkOutput("post-reset full count", 32'(nAcc), 16);
        checkOutput("full scan done latency", 32'((lat >= 16) && (lat <= 17)), 1);

        vecs[0] = '{1'b0, 3'd0, 3'd4, 16'hFFFF, 16, "no rules 0..4"};
        vecs[1] = '{1'b0, 3'd3, 3'd1, 16'h0000, 0,  "min above max"};
        vecs[2] = '{1'b0, 3'd2, 3'd2, 16'h1668, 6,  "pairs only"};
        vecs[3] = '{1'b1, 3'd1, 3'd3, 16'h40C2, 4,  "florencio 1..3"};
        vecs[4] = '{1'b1, 3'd2, 3'd4, 16'hC0C0, 4,  "florencio 2..4"};
        vecs[5] = '{1'b1, 3'd0, 3'd4, 16'hC0C2, 5,  "florencio 0..4"};

        for (int i = 0; i < 6; i++) begin
            programRules(vecs[i].useRules);
            bus.sol_ready = 1'b1;
            pushExpected(vecs[i].expMask);
            startScan(vecs[i].minG, vecs[i].maxG);
            collectScan(60, nAcc, lat);
            checkOutput({vecs[i].name, " count"}, 32'(nAcc), 32'(vecs[i].expN));
`ifdef SOLVER_COUNT_EN
            checkOutput({vecs[i].name, " sol_count"}, 32'(bus.sol_count), 32'(vecs[i].expN));
`endif
        end

        // Back-pressure: first solution must sit unchanged while the consumer stalls.
        programRules(1'b1);
        bus.sol_ready = 1'b0;
        pushExpected(16'h40C2);
        startScan(3'd1, 3'd3);
        for (int k = 0; k < 40 && !bus.sol_valid; k++) @(negedge clk);
        checkOutput("bp first valid", 32'(bus.sol_valid), 1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp data held", 32'(bus.sol_data), 32'h1);
            checkOutput("bp valid held", 32'(bus.sol_valid), 1);
            checkOutput("bp still busy", 32'(bus.busy), 1);
            @(negedge clk);
        end
        bus.sol_ready = 1'b1;
        collectScan(60, nAcc, lat);
        checkOutput("bp count", 32'(nAcc), 4);

        // Reset after the second accepted solution aborts the scan silently.
        pushExpected(16'h40C2);
        startScan(3'd1, 3'd3);
        acc = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.sol_valid && bus.sol_ready) begin
                want = expQ.pop_front();
                checkOutput("pre-reset sol_data", 32'(bus.sol_data), 32'(want));
                acc++;
            end
            @(negedge clk);
            if (acc == 2) break;
        end
        checkOutput("solutions before reset", 32'(acc), 2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort done", 32'(bus.done), 0);
        checkOutput("abort sol_valid", 32'(bus.sol_valid), 0);
        checkOutput("abort sol_data", 32'(bus.sol_data), 0);
        reset = 1'b0;
        expQ.delete();
        doneSeen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("no done after abort", 32'(doneSeen), 0);

        pushExpected(16'h7FFE);
        startScan(3'd1, 3'd3);
        collectScan(60, nAcc, lat);
        checkOutput("rules cleared by reset", 32'(nAcc), 14);

        programRules(1'b1);
        pushExpected(16'h40C2);
        startScan(3'd1, 3'd3);
        collectScan(60, nAcc, lat);
        checkOutput("restart count", 32'(nAcc), 4);

        // Writes and start while busy must be ignored.
        pushExpected(16'h40C2);
        startScan(3'd1, 3'd3);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 3'd5;
        bus.cfg_en     = 1'b1;
        bus.cfg_pos    = '0;
        bus.cfg_neg    = '0;
        bus.cfg_con    = '0;
        bus.min_guests = 3'd0;
        bus.max_guests = 3'd4;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.cfg_we     = 1'b0;
        bus.start      = 1'b0;
        collectScan(60, nAcc, lat);
        checkOutput("busy-ignore count", 32'(nAcc), 4);

        pushExpected(16'h40C2);
        startScan(3'd1, 3'd3);
        collectScan(60, nAcc, lat);
        checkOutput("table intact count", 32'(nAcc), 4);

        // Write and start on the same edge in IDLE: the new rule must govern this scan.
        programRules(1'b0);
        pushExpected(16'hAAAA);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 3'd0;
        bus.cfg_en     = 1'b1;
        bus.cfg_pos    = 4'b0000;
        bus.cfg_neg    = 4'b0000;
        bus.cfg_con    = 4'b0001;
        bus.min_guests = 3'd0;
        bus.max_guests = 3'd4;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.cfg_we     = 1'b0;
        bus.start      = 1'b0;
        collectScan(60, nAcc, lat);
        checkOutput("write+start count", 32'(nAcc), 8);
`ifdef SOLVER_COUNT_EN
        checkOutput("write+start sol_count", 32'(bus.sol_count), 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
